// File: rtl/somador_serial_param_if.sv
// Operand/result bundle for somador_serial_param; SOMADOR_SUB_EN adds the sub control.
// Master drives the request side, slave is the adder.
interface somador_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SOMADOR_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

`ifdef SOMADOR_SUB_EN
    modport master (output start, a, b, carry_in, sub, input ready, done, sum, carry_out);
    modport slave  (input start, a, b, carry_in, sub, output ready, done, sum, carry_out);
`else
    modport master (output start, a, b, carry_in, input ready, done, sum, carry_out);
    modport slave  (input start, a, b, carry_in, output ready, done, sum, carry_out);
`endif
endinterface

// File: rtl/somador_serial_param.sv
// Serial adder: a+b+carry_in, DIGIT bits per clock; SOMADOR_SUB_EN adds sub (a-b-borrow_in).
// Latency: done pulses N=WIDTH/DIGIT cycles after the accepting edge; sum/carry_out held until next completion.
// Backpressure: ready low while BUSY and start ignored; ready is high in the done cycle so back-to-back works.
module somador_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    somador_serial_param_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt, sum_q, b_cap;
    logic [CW-1:0]    count;
    logic [DIGIT-1:0] dsum;
    logic             carry, carry_nxt, carry_out_q, done_q, cin_cap, last;

`ifdef SOMADOR_SUB_EN
    // a - b - borrow_in == a + ~b + ~borrow_in; carry_out then reads as not-borrow
    assign b_cap   = bus.b ^ {WIDTH{bus.sub}};
    assign cin_cap = bus.carry_in ^ bus.sub;
`else
    assign b_cap   = bus.b;
    assign cin_cap = bus.carry_in;
`endif

    assign {carry_nxt, dsum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                             + {{DIGIT{1'b0}}, carry};
    // new digit enters at the top so after N steps the first digit sits at bit 0
    assign res_nxt = (res_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    assign last    = (state == BUSY) && (count == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            carry       <= 1'b0;
            count       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    a_sh  <= bus.a;
                    b_sh  <= b_cap;
                    carry <= cin_cap;
                    count <= '0;
                end
            end else begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                res_sh <= res_nxt;
                carry  <= carry_nxt;
                count  <= count + CW'(1);
                if (last) begin
                    sum_q       <= res_nxt;
                    carry_out_q <= carry_nxt;
                    done_q      <= 1'b1;
                end
            end
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
endmodule
